pdm_modulator: RTL and testbench

First-order sigma-delta modulator. Converts a stream of signed PCM samples into a PDM bitstream plus a matching bit clock. It is the transmit-side counterpart of the PDM microphone capture path. It emulates a MEMS mic, so the capture/printer chain can be driven from host-supplied PCM data (loopback and bring-up). PCM arrives through a small FIFO with a valid/ready handshake.

---
 rtl/pdm_modulator.sv | 126 ++++++++++++
 tb/tb_pdm_modulator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_modulator.sv
// pdm_modulator: first-order sigma-delta PCM-to-PDM transmitter with input FIFO.
// Ports: clk, rst_n (sync, active low), enable, pcm_data/pcm_valid/pcm_ready
//        (push side), pdm_clk/pdm_out (bitstream), underrun pulse, fifo_level.
module pdm_modulator #(
    parameter int CLK_DIV    = 16,
    parameter int DECIM      = 64,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [DATA_W-1:0]               pcm_data,
    input  logic                            pcm_valid,
    output logic                            pcm_ready,
    output logic                            pdm_clk,
    output logic                            pdm_out,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int DW    = $clog2(CLK_DIV);
    localparam int BW    = $clog2(DECIM);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int ACC_W = DATA_W + 2;
    localparam logic [ACC_W-1:0] FS = ACC_W'(1) << (DATA_W - 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] cur_sample;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              tick;
    logic              boundary;
    logic [DW-1:0]     div_nxt;
    logic [DATA_W-1:0] x;
    logic [ACC_W-1:0]  e;
    logic              bit_v;
    logic [ACC_W-1:0]  acc_nxt;

    assign full       = (level == LW'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign pcm_ready  = ~full;
    assign fifo_level = level;
    assign push       = pcm_valid & ~full;

    assign tick     = enable && (div_cnt == DW'(CLK_DIV - 1));
    assign boundary = tick && (bit_cnt == '0);
    // Pop decision uses registered level: a push in the same cycle is not bypassed.
    assign pop      = boundary && !empty;
    assign div_nxt  = tick ? '0 : div_cnt + 1'b1;

    // Error feedback: subtract full scale when a 1 is emitted, add it for a 0.
    always_comb begin
        x       = pop ? mem[rd_ptr] : cur_sample;
        e       = acc + {{2{x[DATA_W-1]}}, x};
        bit_v   = ~e[ACC_W-1];
        acc_nxt = bit_v ? e - FS : e + FS;
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= pcm_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
            cur_sample <= '0;
            pdm_clk    <= 1'b0;
            pdm_out    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (!enable) begin
                div_cnt    <= '0;
                bit_cnt    <= '0;
                acc        <= '0;
                cur_sample <= '0;
                pdm_clk    <= 1'b0;
                pdm_out    <= 1'b0;
                underrun   <= 1'b0;
            end else begin
                div_cnt  <= div_nxt;
                // Low for the first half of the period, high for the second.
                pdm_clk  <= (div_nxt >= DW'(CLK_DIV / 2));
                underrun <= boundary && empty;
                if (tick) begin
                    acc     <= acc_nxt;
                    pdm_out <= bit_v;
                    bit_cnt <= (bit_cnt == BW'(DECIM - 1)) ? '0 : bit_cnt + 1'b1;
                    if (pop) begin
                        cur_sample <= x;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// tb_pdm_modulator: directed self-checking bench for pdm_modulator.
// Ports: none; drives the DUT with default parameters.
module tb_pdm_modulator;

    localparam int CLK_DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        pdm_clk;
    logic        pdm_out;
    logic        underrun;
    logic [2:0]  fifo_level;

    int tests  = 0;
    int failed = 0;
    int und_cyc = 0;

    pdm_modulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pcm_data   (pcm_data),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .pdm_clk    (pdm_clk),
        .pdm_out    (pdm_out),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full pdm_clk period; samples the bit emitted at its tick.
    task automatic tick1(output logic b);
        for (int i = 0; i < CLK_DIV; i++) begin
            @(posedge clk);
            #1;
            if (underrun === 1'b1) und_cyc++;
        end
        b = pdm_out;
    endtask

    task automatic run(input int n, output int ones);
        logic b;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            tick1(b);
            if (b === 1'b1) ones++;
        end
    endtask

    task automatic push(input logic [15:0] d);
        pcm_data  = d;
        pcm_valid = 1'b1;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        b;
        logic [3:0]  p;
        int          ones;
        logic [15:0] vals [5];

        rst_n     = 1'b0;
        enable    = 1'b0;
        pcm_valid = 1'b1;
        pcm_data  = 16'd1234;

        // 1: reset with pushes offered
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pdm_clk", pdm_clk, 0);
        chk("rst_pdm_out", pdm_out, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", pcm_ready, 1);
        rst_n     = 1'b1;
        pcm_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_level_after", fifo_level, 0);

        // 2: x = 0 gives alternating bits, underrun at second boundary
        push(16'd0);
        chk("t2_level_push", fifo_level, 1);
        enable = 1'b1;
        repeat (CLK_DIV / 2) @(posedge clk);
        #1;
        chk("t2_clk_high", pdm_clk, 1);
        chk("t2_dummy_bit", pdm_out, 0);
        repeat (CLK_DIV / 2) @(posedge clk);
        #1;
        chk("t2_clk_fall", pdm_clk, 0);
        chk("t2_level_pop", fifo_level, 0);
        chk("t2_no_und0", underrun, 0);
        p = {3'b000, pdm_out};
        und_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            tick1(b);
            p = {p[2:0], b};
        end
        chk("t2_pattern", p, 4'b1010);
        run(60, ones);
        chk("t2_ones", ones + 2, 32);
        chk("t2_und_none", und_cyc, 0);
        und_cyc = 0;
        tick1(b);
        chk("t2_bit64", b, 1);
        chk("t2_und_pulse", und_cyc, 1);
        @(posedge clk);
        #1;
        chk("t2_und_one_cycle", underrun, 0);
        idle_cycle();
        chk("t2_idle_clk", pdm_clk, 0);
        chk("t2_idle_out", pdm_out, 0);

        // 3: full-scale negative then positive
        push(16'h8000);
        push(16'h7fff);
        chk("t3_level2", fifo_level, 2);
        enable  = 1'b1;
        und_cyc = 0;
        run(64, ones);
        chk("t3_ones_neg", ones, 0);
        chk("t3_level1", fifo_level, 1);
        run(64, ones);
        chk("t3_ones_pos", ones, 64);
        chk("t3_level0", fifo_level, 0);
        chk("t3_und", und_cyc, 0);
        idle_cycle();

        // 4: half scale -> 1,1,0,1 repeating
        push(16'd16384);
        enable = 1'b1;
        p = '0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            tick1(b);
            p = {p[2:0], b};
        end
        chk("t4_pattern", p, 4'b1101);
        run(60, ones);
        chk("t4_ones", ones + 3, 48);
        idle_cycle();

        // 5: fill FIFO while idle, then drain four samples
        vals[0] = 16'd16384;
        vals[1] = 16'h8000;
        vals[2] = 16'h7fff;
        vals[3] = 16'd0;
        vals[4] = 16'd100;
        pcm_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pcm_data = vals[i];
            chk($sformatf("t5_ready%0d", i), pcm_ready, (i < 4) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        pcm_valid = 1'b0;
        chk("t5_level_full", fifo_level, 4);
        enable  = 1'b1;
        und_cyc = 0;
        run(64, ones);
        chk("t5_ones_a", ones, 48);
        chk("t5_level_a", fifo_level, 3);
        run(64, ones);
        chk("t5_ones_b", ones, 0);
        chk("t5_level_b", fifo_level, 2);
        run(64, ones);
        chk("t5_ones_c", ones, 64);
        chk("t5_level_c", fifo_level, 1);
        run(64, ones);
        chk("t5_ones_d", ones, 32);
        chk("t5_level_d", fifo_level, 0);
        chk("t5_und_none", und_cyc, 0);
        tick1(b);
        chk("t5_bit256", b, 0);
        chk("t5_und256", und_cyc, 1);
        tick1(b);
        chk("t5_held_bit", b, 1);
        idle_cycle();

        // 6: abandon a sample mid-stream, then restart cleanly
        push(16'd0);
        push(16'd16384);
        enable = 1'b1;
        run(30, ones);
        tick1(b);
        chk("t6_bit30", b, 1);
        chk("t6_level_mid", fifo_level, 1);
        idle_cycle();
        chk("t6_drop_clk", pdm_clk, 0);
        chk("t6_drop_out", pdm_out, 0);
        chk("t6_drop_level", fifo_level, 1);
        enable = 1'b1;
        repeat (CLK_DIV / 2) @(posedge clk);
        #1;
        chk("t6_dummy_clk", pdm_clk, 1);
        chk("t6_dummy_bit", pdm_out, 0);
        repeat (CLK_DIV / 2) @(posedge clk);
        #1;
        chk("t6_level_pop", fifo_level, 0);
        p = {3'b000, pdm_out};
        for (int i = 0; i < 3; i++) begin
            tick1(b);
            p = {p[2:0], b};
        end
        chk("t6_pattern", p, 4'b1101);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
